text_pixel_renderer: RTL

Consumer side of the character font memory: turns the VGA timing counters into one monochrome text-mode pixel per clock. It reads the character code from the text buffer, forms the glyph-row address for the font ROM, and serializes the returned 8-pixel row. Video sync and blanking are delayed to stay aligned with the pixel stream. It also overlays a blinking underline cursor. It sits between the VGA sync generator and the colour/output stage.

---
 rtl/text_pixel_renderer_if.sv | 27 ++
 rtl/text_pixel_renderer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/text_pixel_renderer_if.sv
`timescale 1ns/1ps
// Memory-side bus of the text renderer: text buffer read port and font ROM read port.
// Both memories return data one cycle after the address is presented.
interface text_pixel_renderer_if #(
  parameter int TEXT_ADDR_WIDTH = 12,
  parameter int FONT_ADDR_WIDTH = 11,
  parameter int FONT_DATA_WIDTH = 8
);
  logic [TEXT_ADDR_WIDTH-1:0] text_addr_o;
  logic [7:0]                 text_data_i;
  logic [FONT_ADDR_WIDTH-1:0] font_addr_o;
  logic [0:FONT_DATA_WIDTH-1] font_data_i;

  modport master (
    output text_addr_o,
    output font_addr_o,
    input  text_data_i,
    input  font_data_i
  );

  modport slave (
    input  text_addr_o,
    input  font_addr_o,
    output text_data_i,
    output font_data_i
  );
endinterface

// File: rtl/text_pixel_renderer.sv
`timescale 1ns/1ps
// Text-mode pixel pipeline: VGA counters -> text RAM -> font ROM -> one pixel per clock,
// with syncs/blank delayed to match and a blinking underline cursor overlaid.
module text_pixel_renderer #(
  parameter int COLS            = 80,
  parameter int ROWS            = 30,
  parameter int TEXT_ADDR_WIDTH = 12,
  parameter int FONT_ADDR_WIDTH = 11,
  parameter int FONT_DATA_WIDTH = 8,
  parameter int BLINK_LOG2      = 5
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [9:0]                   hcount_i,
  input  logic [9:0]                   vcount_i,
  input  logic                         active_i,
  input  logic                         hsync_i,
  input  logic                         vsync_i,
  text_pixel_renderer_if.master        mem,
  input  logic                         cursor_en_i,
  input  logic [6:0]                   cursor_col_i,
  input  logic [4:0]                   cursor_row_i,
  output logic                         pixel_o,
  output logic                         active_o,
  output logic                         hsync_o,
  output logic                         vsync_o
);

  localparam int              ADDR_CALC_W = 16;
  localparam logic [7:0]      LP_COLS     = 8'(COLS);
  localparam logic [5:0]      LP_ROWS     = 6'(ROWS);

  // Everything that must travel alongside the memory reads, one copy per stage.
  typedef struct packed {
    logic [6:0] col;
    logic [4:0] chr_row;
    logic [3:0] glyph_row;
    logic [2:0] px;
    logic       in_text;
    logic       active;
    logic       hsync;
    logic       vsync;
  } stage_t;

  localparam stage_t STAGE_RST = '{
    col:       7'd0,
    chr_row:   5'd0,
    glyph_row: 4'd0,
    px:        3'd0,
    in_text:   1'b0,
    active:    1'b0,
    hsync:     1'b1,
    vsync:     1'b1
  };

  logic [6:0]                  w_col;
  logic [4:0]                  w_chr_row;
  logic [ADDR_CALC_W-1:0]      w_addr_full;
  logic                        w_unused;
  stage_t                      w_s0;
  logic [0:FONT_DATA_WIDTH-1]  w_font_row;
  logic                        w_font_bit;
  logic                        w_vsync_fall;
  logic                        w_blink;
  logic                        w_cur;

  stage_t                      r_pipe [1:4];
  logic [TEXT_ADDR_WIDTH-1:0]  r_text_addr;
  logic [FONT_ADDR_WIDTH-1:0]  r_font_addr;
  logic                        r_inv_d3;
  logic                        r_cur_d3;
  logic                        r_inv_d4;
  logic                        r_cur_d4;
  logic                        r_pixel;
  logic                        r_active;
  logic                        r_hsync;
  logic                        r_vsync;
  logic                        r_vsync_q;
  logic [BLINK_LOG2:0]         r_frame_cnt;

  assign w_col     = hcount_i[9:3];
  assign w_chr_row = vcount_i[8:4];
  // Rows beyond 31 never reach the visible area, so the counter MSB plays no part.
  assign w_unused  = vcount_i[9];

  generate
    if (COLS == 80) begin : g_cols80
      assign w_addr_full = (ADDR_CALC_W'(w_chr_row) << 6)
                         + (ADDR_CALC_W'(w_chr_row) << 4)
                         + ADDR_CALC_W'(w_col);
    end else begin : g_cols_any
      assign w_addr_full = ADDR_CALC_W'(w_chr_row) * ADDR_CALC_W'(COLS)
                         + ADDR_CALC_W'(w_col);
    end
  endgenerate

  always_comb begin
    w_s0           = STAGE_RST;
    w_s0.col       = w_col;
    w_s0.chr_row   = w_chr_row;
    w_s0.glyph_row = vcount_i[3:0];
    w_s0.px        = hcount_i[2:0];
    w_s0.in_text   = active_i & ({1'b0, w_col} < LP_COLS) & ({1'b0, w_chr_row} < LP_ROWS);
    w_s0.active    = active_i;
    w_s0.hsync     = hsync_i;
    w_s0.vsync     = vsync_i;
  end

  // Frame counter for the cursor blink, advanced on each vsync falling edge.
  assign w_vsync_fall = r_vsync_q & ~vsync_i;
  assign w_blink      = r_frame_cnt[BLINK_LOG2];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_vsync_q   <= 1'b1;
      r_frame_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value of its neighbours, independent of statement order.
      r_vsync_q <= vsync_i;
      if (w_vsync_fall) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign w_cur = cursor_en_i & w_blink
               & (r_pipe[2].col == cursor_col_i)
               & (r_pipe[2].chr_row == cursor_row_i)
               & (r_pipe[2].glyph_row >= 4'd14);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: the delay line is reset to the idle video state (blank, syncs
      // deasserted high) so nothing visible leaks out while the pipeline refills.
      for (int i = 1; i <= 4; i++) begin
        r_pipe[i] <= STAGE_RST;
      end
      r_text_addr <= '0;
      r_font_addr <= '0;
      r_inv_d3    <= 1'b0;
      r_cur_d3    <= 1'b0;
      r_inv_d4    <= 1'b0;
      r_cur_d4    <= 1'b0;
    end else begin
      r_pipe[1]   <= w_s0;
      for (int i = 2; i <= 4; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      r_text_addr <= w_addr_full[TEXT_ADDR_WIDTH-1:0];
      r_font_addr <= FONT_ADDR_WIDTH'({mem.text_data_i[6:0], r_pipe[2].glyph_row});
      r_inv_d3    <= mem.text_data_i[7];
      r_cur_d3    <= w_cur;
      r_inv_d4    <= r_inv_d3;
      r_cur_d4    <= r_cur_d3;
    end
  end

  // Bit 0 of the font row is the leftmost pixel, so px indexes the row directly.
  assign w_font_row = mem.font_data_i;
  assign w_font_bit = w_font_row[r_pipe[4].px];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pixel  <= 1'b0;
      r_active <= 1'b0;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
    end else begin
      r_pixel  <= r_pipe[4].in_text & ((w_font_bit ^ r_inv_d4) | r_cur_d4);
      r_active <= r_pipe[4].active;
      r_hsync  <= r_pipe[4].hsync;
      r_vsync  <= r_pipe[4].vsync;
    end
  end

  assign mem.text_addr_o = r_text_addr;
  assign mem.font_addr_o = r_font_addr;
  assign pixel_o         = r_pixel;
  assign active_o        = r_active;
  assign hsync_o         = r_hsync;
  assign vsync_o         = r_vsync;

endmodule
